// File: rtl/wb_sequencer.sv
// Write-back sequencer: steers the register-unit write port for ALU/PC results
// and holds the pipeline while a load waits on data memory, with timeout abort.
`timescale 1ns/1ps
module wb_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       InstValid,
    input  logic       RUWr,
    input  logic [1:0] RUDatawrSrcIn,
    input  logic [4:0] Rd,
    input  logic       MemRdValid,
    input  logic       Flush,
    output logic [1:0] RUDatawrSrc,
    output logic       RUWrEn,
    output logic [4:0] RUWrAddr,
    output logic       Stall,
    output logic       MemErr,
    output logic [15:0] RetireCnt
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned SRC_W = 2;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [SRC_W-1:0] SRC_ALU  = 2'b00;
    localparam logic [SRC_W-1:0] SRC_LOAD = 2'b01;
    localparam logic [SRC_W-1:0] SRC_PC   = 2'b10;
    localparam logic [SRC_W-1:0] SRC_PC_ALIAS = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  to_cnt;
    logic [ADDR_W-1:0] rd_q;

    logic              accept;
    logic              writes_rf;
    logic              is_load;
    logic [SRC_W-1:0]  src_map;

    assign Stall = (state == WAIT_MEM);

    // Decode of the instruction presented at write-back this cycle
    always_comb begin
        accept    = (state == IDLE) && InstValid && !Flush;
        writes_rf = RUWr && (Rd != ADDR_W'(0));
        is_load   = writes_rf && (RUDatawrSrcIn == SRC_LOAD);
        src_map   = (RUDatawrSrcIn == SRC_PC_ALIAS) ? SRC_PC : RUDatawrSrcIn;
    end

    // Sequencer state and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            to_cnt      <= CNT_W'(0);
            rd_q        <= ADDR_W'(0);
            RUWrEn      <= 1'b0;
            MemErr      <= 1'b0;
            RUWrAddr    <= ADDR_W'(0);
            RUDatawrSrc <= SRC_ALU;
            RetireCnt   <= 16'(0);
        end else begin
            RUWrEn <= 1'b0;
            MemErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load) begin
                            rd_q   <= Rd;
                            to_cnt <= CNT_W'(0);
                            state  <= WAIT_MEM;
                        end else if (writes_rf) begin
                            RUWrEn      <= 1'b1;
                            RUWrAddr    <= Rd;
                            RUDatawrSrc <= src_map;
                            RetireCnt   <= RetireCnt + 16'(1);
                        end else begin
                            RetireCnt <= RetireCnt + 16'(1);
                        end
                    end
                end
                WAIT_MEM: begin
                    // Flush beats returning data; data beats the timeout
                    if (Flush) begin
                        state <= IDLE;
                    end else if (MemRdValid) begin
                        RUWrEn      <= 1'b1;
                        RUWrAddr    <= rd_q;
                        RUDatawrSrc <= SRC_LOAD;
                        RetireCnt   <= RetireCnt + 16'(1);
                        state       <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        MemErr    <= 1'b1;
                        RetireCnt <= RetireCnt + 16'(1);
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, max cycles spent in WAIT_MEM before abort (legal 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 InstValid  input  1  instruction present at write-back stage this cycle.
REQ-005 RUWr  input  1  instruction writes the register unit.
REQ-006 RUDatawrSrcIn  input  2  requested source: 00 ALUS, 01 datard (load), 10 PCInc, 11 treated as PCInc.
REQ-007 Rd  input  5  destination register index.
REQ-008 MemRdValid  input  1  data memory read data valid this cycle.
REQ-009 Flush  input  1  pipeline flush.
REQ-010 RUDatawrSrc  output  2  select driven to the 3:1 write-back mux.
REQ-011 RUWrEn  output  1  register unit write enable, one cycle per write.
REQ-012 RUWrAddr  output  5  register unit write address.
REQ-013 Stall  output  1  hold upstream pipeline.
REQ-014 MemErr  output  1  one-cycle pulse on load timeout.
REQ-015 RetireCnt  output  16  count of retired instructions.

Function
REQ-016 FSM states SHALL be IDLE and WAIT_MEM; all outputs SHALL be registered except Stall, which SHALL equal (state==WAIT_MEM).
REQ-017 Accept condition SHALL be: state IDLE, InstValid=1, Flush=0.
REQ-018 Accepted instruction with RUWr=1, Rd!=0, src!=01 SHALL produce RUWrEn=1, RUWrAddr=Rd, RUDatawrSrc=src (11 mapped to 10) in the following cycle; state stays IDLE.
REQ-019 Back-to-back non-load accepts SHALL produce RUWrEn on consecutive cycles, no bubble.
REQ-020 Accepted instruction with RUWr=0 or Rd=0 SHALL produce no write, retire next cycle, stay IDLE.
REQ-021 Accepted load (RUWr=1, Rd!=0, src=01) SHALL latch Rd, clear timeout counter, enter WAIT_MEM; RUWrEn=0 next cycle.
REQ-022 Accepted load with Rd=0 SHALL follow REQ-020 (no wait).
REQ-023 In WAIT_MEM, InstValid SHALL be ignored.
REQ-024 In WAIT_MEM with MemRdValid=1 and Flush=0: next cycle RUWrEn=1, RUDatawrSrc=01, RUWrAddr=latched Rd, state IDLE, Stall low.
REQ-025 MemRdValid sampled in IDLE SHALL be ignored.
REQ-026 In WAIT_MEM, timeout counter SHALL increment each cycle; when it reaches TIMEOUT_CYC-1 with MemRdValid=0, next cycle MemErr=1 for one cycle, no write, state IDLE, instruction counted as retired.
REQ-027 MemRdValid on the timeout cycle SHALL win: normal write, no MemErr.
REQ-028 Flush in WAIT_MEM SHALL abort: state IDLE next cycle, no write, no MemErr, no retire; Flush wins over simultaneous MemRdValid.
REQ-029 Flush in IDLE SHALL block acceptance that cycle; a write already registered from the prior cycle SHALL still complete.
REQ-030 RetireCnt SHALL increment by 1 in the cycle after each write, no-write retirement, or timeout; wraps 0xFFFF->0x0000.
REQ-031 RUWrEn, MemErr SHALL be 0 in every cycle not specified above; RUWrAddr/RUDatawrSrc hold last value.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, RUWrEn=0, MemErr=0, Stall=0, RUDatawrSrc=00, RUWrAddr=0, RetireCnt=0, timeout counter=0, independent of clk.
REQ-033 Reset asserted during WAIT_MEM SHALL discard the pending load with no write.
REQ-034 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 ALU op Rd=5 src=00, then PC op Rd=1 src=10 on next cycle -> RUWrEn high two consecutive cycles, addr 5 then 1, src 00 then 10, RetireCnt=2.
REQ-036 Load Rd=7, MemRdValid after 3 cycles -> Stall high 3 cycles, then RUWrEn=1 addr 7 src 01; InstValid pulses during stall ignored.
REQ-037 Load Rd=9, no MemRdValid, TIMEOUT_CYC=4 -> MemErr single pulse, RUWrEn never high, Stall low after, RetireCnt+1.
REQ-038 Load Rd=3, Flush and MemRdValid same cycle in WAIT_MEM -> no write, no MemErr, RetireCnt unchanged.
REQ-039 Write to Rd=0 src=00 and src=11 op Rd=4 -> no write for Rd=0; Rd=4 written with src=10.
REQ-040 rst_n low mid-WAIT_MEM, release, MemRdValid pulse -> no write; all outputs at reset values.
